fp_convert_compare: RTL and testbench
=====================================

# fp_convert_compare

Single-precision conversion and comparison unit that serves the FPU controller's op codes 0100–1000 (fcvt.s.w, fcvt.w.s, feq, flt, fle). It is the responder end of the two-operand strobe/acknowledge protocol the controller already uses for the adder and multiplier. The controller drives operands, strobes and the output acknowledge. This block acknowledges each operand, computes the result, and holds it with a strobe until the controller acknowledges it.

## Interface
- No parameters.
- clk  in  1  clock; all logic on the rising edge
- rst  in  1  synchronous, active-high reset
- op  in  4  operation code: 0100 fcvt.s.w, 0101 fcvt.w.s, 0110 feq, 0111 flt, 1000 fle; sampled when input_a is accepted
- input_a  in  32  operand A (IEEE-754 single, or signed int32 for fcvt.s.w)
- input_a_stb  in  1  operand A valid
- input_a_ack  out  1  block ready to take operand A
- input_b  in  32  operand B (comparisons only; consumed and ignored for conversions)
- input_b_stb  in  1  operand B valid
- input_b_ack  out  1  block ready to take operand B
- output_z  out  32  result
- output_z_stb  out  1  result valid
- output_z_ack  in  1  result consumed

## Operation
- State machine: GET_A, GET_B, EXEC, NORM, PACK, PUT_Z. Reset state is GET_A.
- GET_A
  - input_a_ack=1.
  - On input_a_stb & input_a_ack: latch input_a and op, drop input_a_ack, go to GET_B.
- GET_B
  - input_b_ack=1.
  - On input_b_stb & input_b_ack: latch input_b, drop input_b_ack, go to EXEC.
  - Both operands are always consumed, for every op.
- Compares (feq/flt/fle)
  - EXEC→PUT_Z. Result is 32'h1 if true, 32'h0 otherwise.
  - Any NaN operand (exp=FF, mant≠0): result 0.
  - +0 and -0 compare equal.
  - Subnormals compare by value.
- fcvt.s.w
  - EXEC: take the magnitude; zero input goes straight to PUT_Z with 0x00000000.
  - NORM: shift the magnitude left 1 bit per cycle until bit31=1, decrementing the exponent each shift.
  - PACK: round to nearest, ties to even, using the low 8 bits (guard, round, sticky). Mantissa carry-out increments the exponent.
  - -2^31 → 0xCF000000.
- fcvt.w.s
  - Rounding is toward zero.
  - EXEC special cases, each going straight to PUT_Z:
    - NaN → 0x7FFFFFFF.
    - Unbiased exponent ≥31: 0x80000000 if the value is exactly -2^31 or negative, else 0x7FFFFFFF.
    - Unbiased exponent <0 (including zero and subnormals) → 0.
  - NORM: shift the 24-bit significand right 1 bit per cycle until the exponent reaches 23. Left shift for exponent 24–30 is done in one step in EXEC.
  - PACK: apply two's-complement negation if the sign bit is set.
- Unsupported op (0000–0011, 1001–1111): EXEC→PUT_Z with output_z=0. No hang.
- PUT_Z
  - output_z_stb=1 and output_z held stable until output_z_ack=1 is sampled.
  - Then output_z_stb drops and the machine returns to GET_A.

## Timing
- Reset values: input_a_ack=0, input_b_ack=0, output_z_stb=0, output_z=0, state=GET_A.
- input_a_ack rises the first cycle after rst is low.
- rst high in any cycle aborts the operation in progress and restores reset values the next edge. rst has priority over any simultaneous stb or ack.
- Each ack is a registered output. At most one operand is accepted per cycle.
- B is accepted no earlier than the cycle after A.
- Latency, from the B-accept edge to the output_z_stb rising edge:
  - compares and unsupported ops: 2 cycles
  - special-case conversions: 2 cycles
  - fcvt.s.w: 3 + (number of left shifts), at most 34
  - fcvt.w.s: 3 + (number of right shifts), at most 26
- Back-to-back: input_a_ack reasserts the cycle after output_z_ack is accepted.
- output_z_stb is never high in the same cycle as input_a_ack or input_b_ack.

## Test plan
- Compares:
  - feq(0x3F800000, 0x3F800000) → 1.
  - flt(0x80000000, 0x00000000) → 0; fle on the same operands → 1.
  - feq/flt/fle with A=0x7FC00000 → 0 for all three.
- fcvt.s.w:
  - 7 → 0x40E00000.
  - 0 → 0x00000000.
  - 0x80000000 → 0xCF000000.
  - 0x7FFFFFFF → 0x4F000000 (rounds up).
  - 16777217 → 0x4B800000 (tie to even).
- fcvt.w.s:
  - 0x40700000 (3.75) → 3.
  - 0xBFC00000 (-1.5) → 0xFFFFFFFF.
  - 0x501502F9 (1e10) → 0x7FFFFFFF.
  - 0xD0000000 (-2^33) → 0x80000000.
  - 0x7FC00000 → 0x7FFFFFFF.
  - 0x00000001 → 0.
- Backpressure: hold output_z_ack low for 5 cycles after output_z_stb rises → output_z_stb stays high and output_z stays stable; input_a_ack=0 throughout.
- Reset mid-operation: assert rst for 1 cycle during fcvt.s.w of input 1 while in NORM → outputs at reset values the next cycle, then a fresh feq(1.0, 1.0) returns 1.
- Unsupported op 0010 with arbitrary operands → output_z=0 with 2-cycle latency, and the block returns to GET_A.

Source files
------------

// File: rtl/fp_convert_compare.sv
// Single-precision int<->float conversion and compare unit.
// Two operands come in and one result goes out, each over a strobe/acknowledge handshake.
module fp_convert_compare (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  op,
    input  logic [31:0] input_a,
    input  logic        input_a_stb,
    output logic        input_a_ack,
    input  logic [31:0] input_b,
    input  logic        input_b_stb,
    output logic        input_b_ack,
    output logic [31:0] output_z,
    output logic        output_z_stb,
    input  logic        output_z_ack
);
    localparam logic [3:0] OP_CVT_S_W = 4'b0100;
    localparam logic [3:0] OP_CVT_W_S = 4'b0101;
    localparam logic [3:0] OP_FEQ     = 4'b0110;
    localparam logic [3:0] OP_FLT     = 4'b0111;
    localparam logic [3:0] OP_FLE     = 4'b1000;

    typedef enum logic [2:0] {GET_A, GET_B, EXEC, NORM, PACK, PUT_Z} state_e;

    state_e      state_q, state_d;
    logic [31:0] a_q, a_d, b_q, b_d, z_q, z_d, mant_q, mant_d;
    logic [3:0]  op_q, op_d;
    logic [7:0]  exp_q, exp_d;
    logic        a_ack_q, a_ack_d, b_ack_q, b_ack_d, z_stb_q, z_stb_d;

    // Compare datapath: NaNs are unordered, and the two zeros are equal.
    logic a_nan, b_nan, both_zero, cmp_eq, cmp_lt, cmp_le, lt_raw;
    assign a_nan     = (&a_q[30:23]) & (|a_q[22:0]);
    assign b_nan     = (&b_q[30:23]) & (|b_q[22:0]);
    assign both_zero = ~(|a_q[30:0]) & ~(|b_q[30:0]);
    assign lt_raw    = both_zero              ? 1'b0 :
                       (a_q[31] != b_q[31])   ? a_q[31] :
                       a_q[31]                ? (b_q[30:0] < a_q[30:0]) :
                                                (a_q[30:0] < b_q[30:0]);
    assign cmp_eq    = ~a_nan & ~b_nan & ((a_q == b_q) | both_zero);
    assign cmp_lt    = ~a_nan & ~b_nan & lt_raw;
    assign cmp_le    = cmp_lt | cmp_eq;

    // Conversion operand fields.
    logic [7:0]  a_exp;
    logic [23:0] a_sig;
    logic [31:0] int_mag, sig_shl;
    logic [2:0]  lshift;
    assign a_exp   = a_q[30:23];
    assign a_sig   = {1'b1, a_q[22:0]};
    assign int_mag = a_q[31] ? (~a_q + 32'd1) : a_q;
    // Exponents 150..157 map to left shifts 0..7; 150 has 3'b110 in its low bits.
    assign lshift  = a_exp[2:0] - 3'd6;
    assign sig_shl = {8'h00, a_sig} << lshift;

    // Round to nearest even on the low byte of the normalised magnitude.
    logic        rnd_up;
    logic [24:0] rounded;
    logic [7:0]  pack_exp;
    logic [22:0] pack_frac;
    assign rnd_up    = mant_q[7] & ((|mant_q[6:0]) | mant_q[8]);
    assign rounded   = {1'b0, mant_q[31:8]} + {24'd0, rnd_up};
    assign pack_exp  = exp_q + {7'd0, rounded[24]};
    assign pack_frac = rounded[24] ? rounded[23:1] : rounded[22:0];

    always_comb begin
        // NOTE: every _d gets its hold value first, so no path through the case can infer a latch.
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        z_d     = z_q;
        op_d    = op_q;
        mant_d  = mant_q;
        exp_d   = exp_q;
        a_ack_d = a_ack_q;
        b_ack_d = b_ack_q;
        z_stb_d = z_stb_q;

        case (state_q)
            GET_A: begin
                a_ack_d = 1'b1;
                if (input_a_stb && a_ack_q) begin
                    a_d     = input_a;
                    op_d    = op;
                    a_ack_d = 1'b0;
                    state_d = GET_B;
                end
            end
            GET_B: begin
                b_ack_d = 1'b1;
                if (input_b_stb && b_ack_q) begin
                    b_d     = input_b;
                    b_ack_d = 1'b0;
                    state_d = EXEC;
                end
            end
            EXEC: begin
                state_d = PUT_Z;
                z_d     = 32'd0;
                case (op_q)
                    OP_FEQ: z_d = {31'd0, cmp_eq};
                    OP_FLT: z_d = {31'd0, cmp_lt};
                    OP_FLE: z_d = {31'd0, cmp_le};
                    OP_CVT_S_W: begin
                        if (a_q != 32'd0) begin
                            mant_d  = int_mag;
                            exp_d   = 8'd158;
                            state_d = int_mag[31] ? PACK : NORM;
                        end
                    end
                    OP_CVT_W_S: begin
                        if (a_nan) begin
                            z_d = 32'h7FFF_FFFF;
                        end else if (a_exp >= 8'd158) begin
                            z_d = a_q[31] ? 32'h8000_0000 : 32'h7FFF_FFFF;
                        end else if (a_exp < 8'd127) begin
                            z_d = 32'd0;
                        end else if (a_exp >= 8'd150) begin
                            mant_d  = sig_shl;
                            state_d = PACK;
                        end else begin
                            // exp_q holds the unbiased exponent while shifting right.
                            mant_d  = {8'h00, a_sig};
                            exp_d   = a_exp - 8'd127;
                            state_d = NORM;
                        end
                    end
                    default: z_d = 32'd0;
                endcase
            end
            NORM: begin
                if (op_q == OP_CVT_S_W) begin
                    mant_d = mant_q << 1;
                    exp_d  = exp_q - 8'd1;
                    if (mant_q[30]) state_d = PACK;
                end else begin
                    mant_d = mant_q >> 1;
                    exp_d  = exp_q + 8'd1;
                    if (exp_q == 8'd22) state_d = PACK;
                end
            end
            PACK: begin
                state_d = PUT_Z;
                if (op_q == OP_CVT_S_W) z_d = {a_q[31], pack_exp, pack_frac};
                else                    z_d = a_q[31] ? (~mant_q + 32'd1) : mant_q;
            end
            PUT_Z: begin
                z_stb_d = 1'b1;
                if (output_z_ack && z_stb_q) begin
                    z_stb_d = 1'b0;
                    a_ack_d = 1'b1;
                    state_d = GET_A;
                end
            end
            default: state_d = GET_A;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= GET_A;
            a_q     <= 32'd0;
            b_q     <= 32'd0;
            z_q     <= 32'd0;
            op_q    <= 4'd0;
            mant_q  <= 32'd0;
            exp_q   <= 8'd0;
            a_ack_q <= 1'b0;
            b_ack_q <= 1'b0;
            z_stb_q <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            z_q     <= z_d;
            op_q    <= op_d;
            mant_q  <= mant_d;
            exp_q   <= exp_d;
            a_ack_q <= a_ack_d;
            b_ack_q <= b_ack_d;
            z_stb_q <= z_stb_d;
        end
    end

    assign input_a_ack  = a_ack_q;
    assign input_b_ack  = b_ack_q;
    assign output_z     = z_q;
    assign output_z_stb = z_stb_q;

endmodule

// File: tb/tb_fp_convert_compare.sv
// Scoreboard bench for fp_convert_compare: expected result and latency are queued
// at drive time, then popped and compared when the result strobe appears.
module tb_fp_convert_compare;
    localparam logic [3:0] OP_CVT_S_W = 4'b0100;
    localparam logic [3:0] OP_CVT_W_S = 4'b0101;
    localparam logic [3:0] OP_FEQ     = 4'b0110;
    localparam logic [3:0] OP_FLT     = 4'b0111;
    localparam logic [3:0] OP_FLE     = 4'b1000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  op = 4'd0;
    logic [31:0] input_a = 32'd0, input_b = 32'd0;
    logic        input_a_stb = 1'b0, input_b_stb = 1'b0, output_z_ack = 1'b0;
    logic        input_a_ack, input_b_ack, output_z_stb;
    logic [31:0] output_z;

    typedef struct {
        logic [31:0] z;
        int          lat;
    } exp_t;

    typedef struct {
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] z;
        int          lat;
    } vec_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    fp_convert_compare dut (
        .clk          (clk),
        .rst          (rst),
        .op           (op),
        .input_a      (input_a),
        .input_a_stb  (input_a_stb),
        .input_a_ack  (input_a_ack),
        .input_b      (input_b),
        .input_b_stb  (input_b_stb),
        .input_b_ack  (input_b_ack),
        .output_z     (output_z),
        .output_z_stb (output_z_stb),
        .output_z_ack (output_z_ack)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_ab(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b,
                           output bit to);
        int cyc = 0;
        to = 1'b0;
        while (!input_a_ack && cyc < 50) begin tick(); cyc++; end
        if (!input_a_ack) begin to = 1'b1; return; end
        op = o; input_a = a; input_a_stb = 1'b1;
        tick();
        input_a_stb = 1'b0;
        cyc = 0;
        while (!input_b_ack && cyc < 50) begin tick(); cyc++; end
        if (!input_b_ack) begin to = 1'b1; return; end
        input_b = b; input_b_stb = 1'b1;
        tick();
        input_b_stb = 1'b0;
    endtask

    // Counts edges from the B-accept edge until output_z_stb is seen high.
    task automatic wait_z(output int lat, output bit to);
        lat = 0;
        while (!output_z_stb && lat < 100) begin tick(); lat++; end
        to = !output_z_stb;
    endtask

    task automatic ack_z();
        output_z_ack = 1'b1;
        tick();
        output_z_ack = 1'b0;
    endtask

    task automatic do_op(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] z, output int lat, output bit to);
        send_ab(o, a, b, to);
        lat = 0;
        z   = 32'hx;
        if (to) return;
        wait_z(lat, to);
        if (to) return;
        z = output_z;
        ack_z();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) tick();
        checks++;
        if ({input_a_ack, input_b_ack, output_z_stb} !== 3'b000 || output_z !== 32'd0) begin
            errors++;
            $display("FAIL reset_values: acks/stb=%b z=%h expected 000 z=00000000",
                     {input_a_ack, input_b_ack, output_z_stb}, output_z);
        end
        rst = 1'b0;
        tick();
        checks++;
        if (input_a_ack !== 1'b1) begin
            errors++;
            $display("FAIL reset_a_ack_rise: input_a_ack=%b expected 1", input_a_ack);
        end
    endtask

    task automatic test_compare();
        vec_t v [11] = '{
            '{OP_FEQ, 32'h3F800000, 32'h3F800000, 32'h1, 2},
            '{OP_FLT, 32'h80000000, 32'h00000000, 32'h0, 2},
            '{OP_FLE, 32'h80000000, 32'h00000000, 32'h1, 2},
            '{OP_FEQ, 32'h00000000, 32'h80000000, 32'h1, 2},
            '{OP_FEQ, 32'h7FC00000, 32'h7FC00000, 32'h0, 2},
            '{OP_FLT, 32'h7FC00000, 32'h3F800000, 32'h0, 2},
            '{OP_FLE, 32'h7FC00000, 32'h3F800000, 32'h0, 2},
            '{OP_FLT, 32'hC0000000, 32'hBF800000, 32'h1, 2},
            '{OP_FLT, 32'h00000001, 32'h00000002, 32'h1, 2},
            '{OP_FLE, 32'h40000000, 32'h3F800000, 32'h0, 2},
            '{OP_FEQ, 32'h3F800000, 32'h3F800001, 32'h0, 2}
        };
        logic [31:0] got;
        int          lat;
        bit          to;
        exp_t        e;
        foreach (v[i]) begin
            sb.push_back('{z: v[i].z, lat: v[i].lat});
            do_op(v[i].op, v[i].a, v[i].b, got, lat, to);
            e = sb.pop_front();
            checks++;
            if (to) begin
                errors++;
                $display("FAIL cmp[%0d]: no result within bound", i);
            end else begin
                if (got !== e.z) begin
                    errors++;
                    $display("FAIL cmp[%0d]: z=%h expected %h", i, got, e.z);
                end
                checks++;
                if (lat !== e.lat) begin
                    errors++;
                    $display("FAIL cmp_lat[%0d]: latency=%0d expected %0d", i, lat, e.lat);
                end
            end
        end
    endtask

    task automatic test_cvt_s_w();
        vec_t v [6] = '{
            '{OP_CVT_S_W, 32'h00000007, 32'h0, 32'h40E00000, 32},
            '{OP_CVT_S_W, 32'h00000000, 32'h0, 32'h00000000, 2},
            '{OP_CVT_S_W, 32'h80000000, 32'h0, 32'hCF000000, 3},
            '{OP_CVT_S_W, 32'h7FFFFFFF, 32'h0, 32'h4F000000, 4},
            '{OP_CVT_S_W, 32'h01000001, 32'h0, 32'h4B800000, 10},
            '{OP_CVT_S_W, 32'hFFFFFFF9, 32'h0, 32'hC0E00000, 32}
        };
        logic [31:0] got;
        int          lat;
        bit          to;
        exp_t        e;
        foreach (v[i]) begin
            sb.push_back('{z: v[i].z, lat: v[i].lat});
            do_op(v[i].op, v[i].a, v[i].b, got, lat, to);
            e = sb.pop_front();
            checks++;
            if (to) begin
                errors++;
                $display("FAIL s_w[%0d]: no result within bound", i);
            end else begin
                if (got !== e.z) begin
                    errors++;
                    $display("FAIL s_w[%0d]: z=%h expected %h", i, got, e.z);
                end
                checks++;
                if (lat !== e.lat) begin
                    errors++;
                    $display("FAIL s_w_lat[%0d]: latency=%0d expected %0d", i, lat, e.lat);
                end
            end
        end
    endtask

    task automatic test_cvt_w_s();
        vec_t v [9] = '{
            '{OP_CVT_W_S, 32'h40700000, 32'h0, 32'h00000003, 25},
            '{OP_CVT_W_S, 32'hBFC00000, 32'h0, 32'hFFFFFFFF, 26},
            '{OP_CVT_W_S, 32'h501502F9, 32'h0, 32'h7FFFFFFF, 2},
            '{OP_CVT_W_S, 32'hD0000000, 32'h0, 32'h80000000, 2},
            '{OP_CVT_W_S, 32'h7FC00000, 32'h0, 32'h7FFFFFFF, 2},
            '{OP_CVT_W_S, 32'h00000001, 32'h0, 32'h00000000, 2},
            '{OP_CVT_W_S, 32'hCF000000, 32'h0, 32'h80000000, 2},
            '{OP_CVT_W_S, 32'h4B000001, 32'h0, 32'h00800001, 3},
            '{OP_CVT_W_S, 32'hCEFFFFFF, 32'h0, 32'h80000080, 3}
        };
        logic [31:0] got;
        int          lat;
        bit          to;
        exp_t        e;
        foreach (v[i]) begin
            sb.push_back('{z: v[i].z, lat: v[i].lat});
            do_op(v[i].op, v[i].a, v[i].b, got, lat, to);
            e = sb.pop_front();
            checks++;
            if (to) begin
                errors++;
                $display("FAIL w_s[%0d]: no result within bound", i);
            end else begin
                if (got !== e.z) begin
                    errors++;
                    $display("FAIL w_s[%0d]: z=%h expected %h", i, got, e.z);
                end
                checks++;
                if (lat !== e.lat) begin
                    errors++;
                    $display("FAIL w_s_lat[%0d]: latency=%0d expected %0d", i, lat, e.lat);
                end
            end
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] held;
        int          lat;
        bit          to;
        exp_t        e;
        sb.push_back('{z: 32'h1, lat: 2});
        send_ab(OP_FLE, 32'h3F800000, 32'h40000000, to);
        if (!to) wait_z(lat, to);
        e = sb.pop_front();
        checks++;
        if (to) begin
            errors++;
            $display("FAIL bp_start: no result within bound");
            return;
        end
        held = output_z;
        if (held !== e.z) begin
            errors++;
            $display("FAIL bp_value: z=%h expected %h", held, e.z);
        end
        for (int c = 0; c < 5; c++) begin
            tick();
            checks++;
            if (output_z_stb !== 1'b1 || output_z !== held || input_a_ack !== 1'b0 || input_b_ack !== 1'b0) begin
                errors++;
                $display("FAIL bp_hold[%0d]: stb=%b z=%h a_ack=%b b_ack=%b expected 1 %h 0 0",
                         c, output_z_stb, output_z, input_a_ack, input_b_ack, held);
            end
        end
        ack_z();
        checks++;
        if (output_z_stb !== 1'b0 || input_a_ack !== 1'b1) begin
            errors++;
            $display("FAIL bp_release: stb=%b a_ack=%b expected 0 1", output_z_stb, input_a_ack);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] got;
        int          lat;
        bit          to;
        exp_t        e;
        for (int i = 0; i < 3; i++) begin
            sb.push_back('{z: 32'h40000000 + (32'(i) << 22), lat: 32});
            do_op(OP_CVT_S_W, 32'd2 + 32'(i), 32'h0, got, lat, to);
            e = sb.pop_front();
            checks++;
            if (to || got !== e.z) begin
                errors++;
                $display("FAIL b2b_value[%0d]: z=%h expected %h timeout=%0d", i, got, e.z, to);
            end
            checks++;
            if (input_a_ack !== 1'b1) begin
                errors++;
                $display("FAIL b2b_a_ack[%0d]: input_a_ack=%b expected 1", i, input_a_ack);
            end
        end
    endtask

    task automatic test_reset_mid_op();
        logic [31:0] got;
        int          lat;
        bit          to;
        exp_t        e;
        send_ab(OP_CVT_S_W, 32'd1, 32'h0, to);
        repeat (3) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if (to || {input_a_ack, input_b_ack, output_z_stb} !== 3'b000 || output_z !== 32'd0) begin
            errors++;
            $display("FAIL mid_reset: acks/stb=%b z=%h expected 000 z=00000000",
                     {input_a_ack, input_b_ack, output_z_stb}, output_z);
        end
        tick();
        checks++;
        if (input_a_ack !== 1'b1) begin
            errors++;
            $display("FAIL mid_reset_a_ack: input_a_ack=%b expected 1", input_a_ack);
        end
        sb.push_back('{z: 32'h1, lat: 2});
        do_op(OP_FEQ, 32'h3F800000, 32'h3F800000, got, lat, to);
        e = sb.pop_front();
        checks++;
        if (to || got !== e.z || lat !== e.lat) begin
            errors++;
            $display("FAIL mid_reset_feq: z=%h lat=%0d expected %h lat=%0d", got, lat, e.z, e.lat);
        end
    endtask

    task automatic test_unsupported();
        logic [3:0]  ops [3] = '{4'b0010, 4'b0000, 4'b1111};
        logic [31:0] got;
        int          lat;
        bit          to;
        exp_t        e;
        foreach (ops[i]) begin
            sb.push_back('{z: 32'h0, lat: 2});
            do_op(ops[i], 32'hDEADBEEF, 32'h12345678, got, lat, to);
            e = sb.pop_front();
            checks++;
            if (to || got !== e.z || lat !== e.lat) begin
                errors++;
                $display("FAIL unsup[%0d]: z=%h lat=%0d expected %h lat=%0d", i, got, lat, e.z, e.lat);
            end
            checks++;
            if (input_a_ack !== 1'b1) begin
                errors++;
                $display("FAIL unsup_return[%0d]: input_a_ack=%b expected 1", i, input_a_ack);
            end
        end
    endtask

    initial begin
        test_reset();
        test_compare();
        test_cvt_s_w();
        test_cvt_w_s();
        test_backpressure();
        test_back_to_back();
        test_reset_mid_op();
        test_unsupported();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule
